mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; nRST  in  1  asynchronous active-low reset.
REQ-002 The instruction port SHALL be: iREN  in  1  icache read request; iaddr  in  32  icache word address; iwait  out  1  icache stall; iload  out  32  icache read data.
REQ-003 The data port SHALL be: dREN  in  1  dcache read request; dWEN  in  1  dcache write request; daddr  in  32  dcache word address; dstore  in  32  dcache write data; dwait  out  1  dcache stall; dload  out  32  dcache read data.
REQ-004 The RAM port SHALL be: ramREN  out  1  RAM read; ramWEN  out  1  RAM write; ramaddr  out  32  RAM address; ramstore  out  32  RAM write data; ramload  in  32  RAM read data; ramwait  in  1  RAM not ready.

Function
REQ-005 The block SHALL share the single RAM port between icache and dcache, using a registered state machine with states IDLE, GNT_I and GNT_D.
REQ-006 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL be 0, and iwait and dwait SHALL be 1.
REQ-007 IDLE SHALL go to GNT_D when the dcache requests (dREN or dWEN), or to GNT_I when only iREN is set; a pending request SHALL see a grant one cycle after assertion.
REQ-008 In GNT_I, the RAM signals SHALL be driven from the icache (ramREN=iREN, ramWEN=0, ramaddr=iaddr), with iwait=ramwait, iload=ramload and dwait=1.
REQ-009 In GNT_D, the RAM signals SHALL be driven from the dcache (ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore), with dwait=ramwait, dload=ramload and iwait=1.
REQ-010 If dREN and dWEN are both set, the write SHALL take precedence: ramWEN=1 and ramREN=0.
REQ-011 In any state other than the one driving it, iload and dload SHALL be 0.
REQ-012 GNT_I SHALL return to IDLE on the first cycle with ramwait=0 (single-word access), or when iREN drops.
REQ-013 A 2-bit burst counter SHALL count completed dcache words (cycles in GNT_D with ramwait=0); it SHALL be cleared on entry to GNT_D and SHALL saturate at 2.
REQ-014 GNT_D SHALL return to IDLE when dREN and dWEN are both 0, or in the same cycle the counter reaches 2, so that a two-word block transfer (two back-to-back words) is never interleaved with icache traffic.
REQ-015 If the granted requester drops its request mid-access, the state SHALL go to IDLE next cycle, with no RAM enable asserted in that cycle.
REQ-016 The last_grant flag SHALL record the most recent granted requester and SHALL be updated on every IDLE-to-GNT transition.
REQ-017 The outputs SHALL be combinational from the state and the inputs, and there SHALL be no combinational path from ramwait to the state selection in IDLE.

Reset
REQ-018 While nRST=0, the block SHALL hold state=IDLE, burst counter=0, last_grant=icache, iwait=1, dwait=1, RAM enables 0, and all data and address outputs 0.
REQ-019 A reset asserted mid-burst SHALL abort the burst immediately, with RAM enables deasserted asynchronously and no pending word completed.

Configuration
REQ-020 The macro MEM_ARBITER_RR_EN SHALL select round-robin arbitration: when both requesters are pending in IDLE, the one not equal to last_grant is granted.
REQ-021 Without MEM_ARBITER_RR_EN, arbitration SHALL use fixed priority, with the dcache always winning a simultaneous request and last_grant still tracked but unused.

Verification
REQ-022 Reset is released with iREN=1, iaddr=0x40, ramload=0xDEADBEEF and ramwait=0 -> GNT_I on cycle 1, iwait=0, iload=0xDEADBEEF, and back to IDLE on cycle 2.
REQ-023 dREN=1 with daddr 0x100 then 0x104, ramwait low 1 cycle in 3 -> ramREN held, exactly 2 dwait=0 pulses, iREN=1 throughout never granted until the burst ends.
REQ-024 iREN and dWEN rise in the same cycle, dstore=0x12345678, without the macro -> GNT_D first with ramWEN=1 and ramstore=0x12345678, then GNT_I.
REQ-025 The same stimulus as REQ-024 with MEM_ARBITER_RR_EN and last_grant=dcache -> GNT_I first, then GNT_D.
REQ-026 nRST is pulsed low during GNT_D after 1 word -> ramWEN/ramREN go 0 immediately, state=IDLE, counter=0, and the next dREN starts a fresh 2-word burst.
REQ-027 dREN drops while ramwait=1 in GNT_D -> IDLE next cycle, dwait=1, no ram enable asserted.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between icache, dcache, the memory arbiter and the shared RAM.
// The slave modport is the arbiter's view; master is the caches'/RAM model's view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramwait;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramwait,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramwait,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache; dcache two-word bursts are never split.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is fixed dcache priority.
module mem_arbiter (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t      r_state;
  state_t      w_nextState;
  grant_t      r_lastGrant;
  grant_t      w_nextLastGrant;
  grant_t      w_winner;
  logic [1:0]  r_burstCnt;
  logic [1:0]  w_nextBurstCnt;

  logic        w_dReq;
  logic        w_wordDone;
  logic        w_burstDone;

  logic        w_iwait;
  logic [31:0] w_iload;
  logic        w_dwait;
  logic [31:0] w_dload;
  logic        w_ramREN;
  logic        w_ramWEN;
  logic [31:0] w_ramaddr;
  logic [31:0] w_ramstore;

  assign w_dReq      = bus.dREN | bus.dWEN;
  assign w_wordDone  = (r_state == GNT_D) && !bus.ramwait;
  // The second completed word closes the burst on the same edge the counter reaches 2.
  assign w_burstDone = w_wordDone && (r_burstCnt == 2'd1);

  // Winner of a request seen in IDLE; depends only on requests, never on ramwait.
  always_comb begin
    w_winner = GRANT_I;
    if (w_dReq && bus.iREN) begin
`ifdef MEM_ARBITER_RR_EN
      w_winner = (r_lastGrant == GRANT_D) ? GRANT_I : GRANT_D;
`else
      w_winner = GRANT_D;
`endif
    end else if (w_dReq) begin
      w_winner = GRANT_D;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextLastGrant = r_lastGrant;
    w_nextBurstCnt  = r_burstCnt;
    w_iwait         = 1'b1;
    w_iload         = 32'd0;
    w_dwait         = 1'b1;
    w_dload         = 32'd0;
    w_ramREN        = 1'b0;
    w_ramWEN        = 1'b0;
    w_ramaddr       = 32'd0;
    w_ramstore      = 32'd0;

    case (r_state)
      IDLE: begin
        if (w_dReq || bus.iREN) begin
          w_nextState     = (w_winner == GRANT_D) ? GNT_D : GNT_I;
          w_nextLastGrant = w_winner;
        end
      end

      GNT_I: begin
        w_ramREN  = bus.iREN;
        w_ramaddr = bus.iaddr;
        w_iwait   = bus.ramwait;
        w_iload   = bus.ramload;
        if (!bus.iREN || !bus.ramwait) begin
          w_nextState = IDLE;
        end
      end

      GNT_D: begin
        // A simultaneous read and write is treated as a write.
        w_ramWEN   = bus.dWEN;
        w_ramREN   = bus.dREN & ~bus.dWEN;
        w_ramaddr  = bus.daddr;
        w_ramstore = bus.dstore;
        w_dwait    = bus.ramwait;
        w_dload    = bus.ramload;
        if (!w_dReq || w_burstDone) begin
          w_nextState = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase

    if ((r_state != GNT_D) && (w_nextState == GNT_D)) begin
      w_nextBurstCnt = 2'd0;
    end else if (w_wordDone && (r_burstCnt != 2'd2)) begin
      w_nextBurstCnt = r_burstCnt + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_lastGrant <= GRANT_I;
      r_burstCnt  <= 2'd0;
    end else begin
      r_state     <= w_nextState;
      r_lastGrant <= w_nextLastGrant;
      r_burstCnt  <= w_nextBurstCnt;
    end
  end

  assign bus.iwait    = w_iwait;
  assign bus.iload    = w_iload;
  assign bus.dwait    = w_dwait;
  assign bus.dload    = w_dload;
  assign bus.ramREN   = w_ramREN;
  assign bus.ramWEN   = w_ramWEN;
  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level owner/word-count model.
module tb_mem_arbiter;

  logic CLK;
  logic nRST;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic        ramwait;
  } in_t;

  typedef struct packed {
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  int   checks;
  int   failures;
  in_t  cur;

  // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache) and words done.
  int   mOwner;
  bit   mLastD;
  int   mWords;

  function automatic in_t mkIn(input logic iREN, input logic [31:0] iaddr,
                               input logic dREN, input logic dWEN,
                               input logic [31:0] daddr, input logic [31:0] dstore,
                               input logic [31:0] ramload, input logic ramwait);
    in_t x;
    x.iREN = iREN; x.iaddr = iaddr; x.dREN = dREN; x.dWEN = dWEN;
    x.daddr = daddr; x.dstore = dstore; x.ramload = ramload; x.ramwait = ramwait;
    return x;
  endfunction

  function automatic out_t mkOut(input logic iwait, input logic [31:0] iload,
                                 input logic dwait, input logic [31:0] dload,
                                 input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] store);
    out_t o;
    o.iwait = iwait; o.iload = iload; o.dwait = dwait; o.dload = dload;
    o.ramREN = ren; o.ramWEN = wen; o.ramaddr = addr; o.ramstore = store;
    return o;
  endfunction

  function automatic out_t modelOuts(input in_t x);
    out_t o;
    o = mkOut(1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    if (mOwner == 1) begin
      o = mkOut(x.ramwait, x.ramload, 1'b1, 32'd0, x.iREN, 1'b0, x.iaddr, 32'd0);
    end else if (mOwner == 2) begin
      o = mkOut(1'b1, 32'd0, x.ramwait, x.ramload, x.dREN && !x.dWEN, x.dWEN,
                x.daddr, x.dstore);
    end
    return o;
  endfunction

  task automatic modelReset();
    mOwner = 0;
    mLastD = 1'b0;
    mWords = 0;
  endtask

  task automatic modelAdvance(input in_t x);
    bit dReq;
    bit pickD;
    dReq = x.dREN || x.dWEN;
    if (mOwner == 0) begin
      if (dReq && x.iREN) pickD = RR_EN ? !mLastD : 1'b1;
      else                pickD = dReq;
      if (dReq || x.iREN) begin
        mOwner = pickD ? 2 : 1;
        mLastD = pickD;
        mWords = 0;
      end
    end else if (mOwner == 1) begin
      if (!x.iREN || !x.ramwait) mOwner = 0;
    end else begin
      if (!x.ramwait && mWords < 2) mWords = mWords + 1;
      if (!dReq || (!x.ramwait && mWords == 2)) mOwner = 0;
    end
  endtask

  task automatic applyStimulus(input in_t x);
    cur         = x;
    bus.iREN    = x.iREN;
    bus.iaddr   = x.iaddr;
    bus.dREN    = x.dREN;
    bus.dWEN    = x.dWEN;
    bus.daddr   = x.daddr;
    bus.dstore  = x.dstore;
    bus.ramload = x.ramload;
    bus.ramwait = x.ramwait;
  endtask

  function automatic out_t sampleOuts();
    return mkOut(bus.iwait, bus.iload, bus.dwait, bus.dload,
                 bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
  endfunction

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = sampleOuts();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got iwait=%b iload=%h dwait=%b dload=%h ren=%b wen=%b addr=%h store=%h; want iwait=%b iload=%h dwait=%b dload=%h ren=%b wen=%b addr=%h store=%h",
               name, act.iwait, act.iload, act.dwait, act.dload, act.ramREN, act.ramWEN,
               act.ramaddr, act.ramstore, exp.iwait, exp.iload, exp.dwait, exp.dload,
               exp.ramREN, exp.ramWEN, exp.ramaddr, exp.ramstore);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelAdvance(cur);
    @(negedge CLK);
  endtask

  task automatic step(input string name, input in_t x);
    applyStimulus(x);
    #1;
    checkOutput(name, modelOuts(x));
    tick();
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    vec_t  tbl [18];
    out_t  idleOut;
    in_t   x;
    in_t   x2;
    int    renHeld;
    int    dwaitPulses;
    int    iGrantEarly;
    logic [31:0] addrAt6;
    bit    seenSecond;

    checks   = 0;
    failures = 0;
    idleOut  = mkOut(1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    tbl[0]  = '{mkIn(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0), idleOut};
    tbl[1]  = '{mkIn(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0),
                mkOut(0, 32'hDEADBEEF, 1, 0, 1, 0, 32'h40, 0)};
    tbl[2]  = '{mkIn(0, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0), idleOut};
    tbl[3]  = '{mkIn(1, 32'h80, 0, 1, 32'h200, 32'h12345678, 0, 1), idleOut};
    tbl[4]  = '{mkIn(1, 32'h80, 0, 1, 32'h200, 32'h12345678, 0, 1),
                mkOut(1, 0, 1, 0, 0, 1, 32'h200, 32'h12345678)};
    tbl[5]  = '{mkIn(1, 32'h80, 0, 1, 32'h200, 32'h12345678, 32'hAAAA5555, 0),
                mkOut(1, 0, 0, 32'hAAAA5555, 0, 1, 32'h200, 32'h12345678)};
    tbl[6]  = '{mkIn(1, 32'h80, 0, 0, 32'h200, 32'h12345678, 0, 1),
                mkOut(1, 0, 1, 0, 0, 0, 32'h200, 32'h12345678)};
    tbl[7]  = '{mkIn(1, 32'h80, 0, 0, 0, 0, 0, 1), idleOut};
    tbl[8]  = '{mkIn(1, 32'h80, 0, 0, 0, 0, 32'h11, 1),
                mkOut(1, 32'h11, 1, 0, 1, 0, 32'h80, 0)};
    tbl[9]  = '{mkIn(0, 32'h80, 0, 0, 0, 0, 32'h11, 1),
                mkOut(1, 32'h11, 1, 0, 0, 0, 32'h80, 0)};
    tbl[10] = '{mkIn(0, 0, 1, 0, 32'h300, 0, 32'h22, 1), idleOut};
    tbl[11] = '{mkIn(0, 0, 1, 0, 32'h300, 0, 32'h22, 1),
                mkOut(1, 0, 1, 32'h22, 1, 0, 32'h300, 0)};
    tbl[12] = '{mkIn(0, 0, 0, 0, 32'h300, 0, 32'h22, 1),
                mkOut(1, 0, 1, 32'h22, 0, 0, 32'h300, 0)};
    tbl[13] = '{mkIn(0, 0, 0, 0, 0, 0, 0, 0), idleOut};
    tbl[14] = '{mkIn(0, 0, 1, 1, 32'h400, 32'hCAFEF00D, 0, 1), idleOut};
    tbl[15] = '{mkIn(0, 0, 1, 1, 32'h400, 32'hCAFEF00D, 0, 1),
                mkOut(1, 0, 1, 0, 0, 1, 32'h400, 32'hCAFEF00D)};
    tbl[16] = '{mkIn(0, 0, 0, 0, 0, 0, 0, 1), idleOut};
    tbl[17] = '{mkIn(0, 0, 0, 0, 0, 0, 0, 0), idleOut};

    // Reset held with an active icache request: everything must stay quiet.
    nRST = 1'b0;
    modelReset();
    applyStimulus(tbl[0].stim);
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("reset_hold", idleOut);
    nRST = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].stim);
      #1;
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
      checkOutput($sformatf("vec%0d_model", i), modelOuts(tbl[i].stim));
      tick();
    end

    // Simultaneous icache read and dcache write with last grant = dcache.
    x = mkIn(1, 32'h80, 0, 1, 32'h200, 32'h12345678, 0, 0);
    step("arb_idle", x);
    applyStimulus(x);
    #1;
    checkOutput("arb_first_model", modelOuts(x));
    checkVal("arb_first_addr", bus.ramaddr, RR_EN ? 32'h80 : 32'h200);
    checkVal("arb_first_wen", {31'd0, bus.ramWEN}, RR_EN ? 32'd0 : 32'd1);
    checkVal("arb_first_store", bus.ramstore, RR_EN ? 32'd0 : 32'h12345678);
    tick();
    x2 = RR_EN ? mkIn(0, 32'h80, 0, 1, 32'h200, 32'h12345678, 0, 0)
               : mkIn(1, 32'h80, 0, 0, 32'h200, 32'h12345678, 0, 0);
    seenSecond = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(x2);
      #1;
      checkOutput("arb_second_model", modelOuts(x2));
      if (RR_EN ? (bus.ramWEN && bus.ramaddr == 32'h200)
                : (bus.ramREN && bus.ramaddr == 32'h80))
        seenSecond = 1'b1;
      tick();
    end
    checkVal("arb_second_grant", {31'd0, seenSecond}, 32'd1);
    step("arb_drain0", mkIn(0, 0, 0, 0, 0, 0, 0, 0));
    step("arb_drain1", mkIn(0, 0, 0, 0, 0, 0, 0, 0));

    // Two-word dcache read burst with icache pending; ramwait low one cycle in three.
    renHeld = 0; dwaitPulses = 0; iGrantEarly = 0; addrAt6 = 32'd0;
    for (int k = 0; k <= 8; k++) begin
      x = mkIn(k >= 1, 32'h60, k <= 6, 0, (k <= 3) ? 32'h100 : 32'h104, 0,
               32'hB000_0000 + k, (k >= 1 && k <= 6) ? ((k % 3) != 0) : 1'b0);
      applyStimulus(x);
      #1;
      checkOutput("burst_model", modelOuts(x));
      if (k >= 1 && k <= 6) renHeld += bus.ramREN;
      if (k <= 7) begin
        dwaitPulses += !bus.dwait;
        iGrantEarly += !bus.iwait;
      end
      if (k == 6) addrAt6 = bus.ramaddr;
      if (k == 8) checkVal("burst_icache_after", {31'd0, bus.iwait}, 32'd0);
      tick();
    end
    checkVal("burst_ren_held", renHeld, 6);
    checkVal("burst_dwait_pulses", dwaitPulses, 2);
    checkVal("burst_icache_blocked", iGrantEarly, 0);
    checkVal("burst_second_addr", addrAt6, 32'h104);
    step("burst_drain", mkIn(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset pulse in the middle of a dcache burst, then a fresh two-word burst.
    x = mkIn(0, 0, 1, 0, 32'h500, 0, 32'h55, 0);
    step("rst_idle", x);
    step("rst_word1", x);
    x = mkIn(0, 0, 1, 0, 32'h500, 0, 32'h55, 1);
    applyStimulus(x);
    #1;
    checkOutput("rst_before", modelOuts(x));
    #1 nRST = 1'b0;
    #1;
    checkVal("rst_ren", {31'd0, bus.ramREN}, 32'd0);
    checkVal("rst_wen", {31'd0, bus.ramWEN}, 32'd0);
    checkVal("rst_addr", bus.ramaddr, 32'd0);
    checkVal("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    checkVal("rst_dload", bus.dload, 32'd0);
    modelReset();
    #1 nRST = 1'b1;
    tick();
    x = mkIn(0, 0, 1, 0, 32'h500, 0, 32'h66, 0);
    step("rst_fresh_word1", x);
    applyStimulus(x);
    #1;
    checkOutput("rst_fresh_word2_model", modelOuts(x));
    checkVal("rst_fresh_word2_ren", {31'd0, bus.ramREN}, 32'd1);
    tick();
    applyStimulus(x);
    #1;
    checkVal("rst_fresh_end_dwait", {31'd0, bus.dwait}, 32'd1);
    checkOutput("rst_fresh_end_model", modelOuts(x));
    tick();
    step("rst_drain0", mkIn(0, 0, 0, 0, 0, 0, 0, 0));
    step("rst_drain1", mkIn(0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic with sticky requests so bursts and contention occur.
    x = mkIn(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) x.iREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) x.dREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) x.dWEN = 1'($urandom_range(0, 1));
      x.iaddr   = $urandom;
      x.daddr   = $urandom;
      x.dstore  = $urandom;
      x.ramload = $urandom;
      x.ramwait = 1'($urandom_range(0, 1));
      step("rand", x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
